// File: rtl/linreg_pkg.sv
// Shared definitions for the linear-regression sequencer.
//   state_e    : sequencer FSM states
//   DATA_W_DEF : default datapath width
//   idx_width  : coefficient address width for a given feature count (at least 1 bit)
package linreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 32;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/linreg_mac.sv
// Combinational multiply-accumulate step for the linear-regression sequencer.
// Ports:
//   acc_i  : running accumulator (signed)
//   feat_i : feature value (signed)
//   coef_i : coefficient value (signed)
//   acc_o  : acc_i + low DATA_W bits of feat_i*coef_i, wrapping
//   ovf_o  : product did not fit in DATA_W signed, or the add overflowed
module linreg_mac
    import linreg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] acc_i,
    input  logic signed [DATA_W-1:0] feat_i,
    input  logic signed [DATA_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] acc_o,
    output logic                     ovf_o
);

    localparam int PROD_W = 2 * DATA_W;

    function automatic logic signed [DATA_W-1:0] trunc_prod(input logic signed [PROD_W-1:0] p);
        return p[DATA_W-1:0];
    endfunction

    // The product fits only when every bit above the kept sign bit equals that sign bit.
    function automatic logic prod_ovf(input logic signed [PROD_W-1:0] p);
        logic [DATA_W:0] hi;
        hi = p[PROD_W-1:DATA_W-1];
        return !((&hi) || !(|hi));
    endfunction

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] prod_t;

    assign prod   = PROD_W'(feat_i) * PROD_W'(coef_i);
    assign prod_t = trunc_prod(prod);
    assign acc_o  = acc_i + prod_t;
    assign ovf_o  = prod_ovf(prod) || add_ovf(acc_i, prod_t, acc_o);

endmodule

// File: rtl/linreg_sequencer.sv
// Control and accumulation sequencer: price = intercept + sum(coef[i]*feat[i]).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i/abort_i : begin a new inference (IDLE only) / cancel one in progress
//   busy_o          : high whenever not IDLE
//   feat_valid_i/feat_ready_o/feat_data_i : feature stream handshake
//   coef_addr_o/coef_data_i : synchronous coefficient ROM port (data one cycle after address)
//   intercept_i     : sampled with start
//   price_o/rout_o/ovf_o : last result, one-cycle update strobe, sticky overflow flag
module linreg_sequencer
    import linreg_pkg::*;
#(
    parameter int N_FEAT = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = idx_width(N_FEAT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    input  logic                     feat_valid_i,
    output logic                     feat_ready_o,
    input  logic signed [DATA_W-1:0] feat_data_i,
    output logic        [IDX_W-1:0]  coef_addr_o,
    input  logic signed [DATA_W-1:0] coef_data_i,
    input  logic signed [DATA_W-1:0] intercept_i,
    output logic signed [DATA_W-1:0] price_o,
    output logic                     rout_o,
    output logic                     ovf_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_e                   state_q, state_d;
    logic        [IDX_W-1:0]  idx_q, idx_d;
    logic        [IDX_W-1:0]  addr_q, addr_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] feat_q, feat_d;
    logic signed [DATA_W-1:0] price_q, price_d;
    logic                     rout_q, rout_d;
    logic                     ovf_q, ovf_d;

    logic signed [DATA_W-1:0] mac_acc;
    logic                     mac_ovf;

    linreg_mac #(.DATA_W(DATA_W)) u_mac (
        .acc_i  (acc_q),
        .feat_i (feat_q),
        .coef_i (coef_data_i),
        .acc_o  (mac_acc),
        .ovf_o  (mac_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            feat_q  <= '0;
            price_q <= '0;
            rout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            feat_q  <= feat_d;
            price_q <= price_d;
            rout_q  <= rout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        feat_d  = feat_q;
        price_d = price_q;
        rout_d  = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    acc_d   = intercept_i;
                    idx_d   = '0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (feat_valid_i) begin
                    feat_d  = feat_data_i;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (abort_i) begin
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = mac_acc;
                    ovf_d = ovf_q | mac_ovf;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        // Address moves here so it is stable across the whole next LOAD.
                        idx_d   = idx_q + 1'b1;
                        addr_d  = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                price_d = acc_q;
                rout_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign feat_ready_o = (state_q == ST_LOAD);
    assign coef_addr_o  = addr_q;
    assign price_o      = price_q;
    assign rout_o       = rout_q;
    assign ovf_o        = ovf_q;

endmodule
